ms_sched: RTL

Round-robin scheduler that shares one maze-solver core among `N_REQ` requesters. It grants the solver to one requester at a time and streams that requester's 225-bit maze serially into the solver. It then waits for the solver's path output or dead-maze indication and routes the result back to the owning requester, enforcing a solve timeout. It sits between the requester-side maze sources and the solver's `maze`/`in_valid` and `out_valid`/`maze_not_valid`/`out_x`/`out_y` pins.

---
 rtl/ms_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ms_sched.sv
// ms_sched: round-robin arbiter that shares one maze-solver core among N_REQ requesters.
// It streams the owner's maze serially into the solver and routes path beats back, with a solve timeout.
module ms_sched #(
  parameter int N_REQ   = 2,
  parameter int CELLS   = 225,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] src_valid,
  input  logic [N_REQ-1:0] src_maze,
  output logic [N_REQ-1:0] gnt,
  output logic             ms_in_valid,
  output logic             ms_maze,
  input  logic             ms_out_valid,
  input  logic             ms_maze_not_valid,
  input  logic [3:0]       ms_out_x,
  input  logic [3:0]       ms_out_y,
  output logic [N_REQ-1:0] rsp_valid,
  output logic [3:0]       rsp_x,
  output logic [3:0]       rsp_y,
  output logic             rsp_not_valid,
  output logic             busy,
  output logic             timeout
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SOLVE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [OW-1:0]    owner_r, owner_s;
  logic [OW-1:0]    last_owner_r, last_owner_s;
  logic [7:0]       bit_cnt_r, bit_cnt_s;
  logic [TW-1:0]    tmo_cnt_r, tmo_cnt_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic             ms_in_valid_r, ms_in_valid_s;
  logic             ms_maze_r, ms_maze_s;
  logic [N_REQ-1:0] rsp_valid_r, rsp_valid_s;
  logic [3:0]       rsp_x_r, rsp_x_s;
  logic [3:0]       rsp_y_r, rsp_y_s;
  logic             rsp_not_valid_r, rsp_not_valid_s;
  logic             busy_r, busy_s;
  logic             timeout_r, timeout_s;

  logic             found_s;
  logic [OW-1:0]    pick_s;
  logic [OW-1:0]    idx_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting just after the previous owner.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_owner_r;
    idx_s   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_s = OW'((int'(last_owner_r) + i) % N_REQ);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/LOAD/SOLVE/DRAIN sequencer.
  always_comb begin
    state_s         = state_r;
    owner_s         = owner_r;
    last_owner_s    = last_owner_r;
    bit_cnt_s       = bit_cnt_r;
    tmo_cnt_s       = tmo_cnt_r;
    gnt_s           = gnt_r;
    ms_in_valid_s   = 1'b0;
    ms_maze_s       = 1'b0;
    rsp_valid_s     = '0;
    rsp_x_s         = rsp_x_r;
    rsp_y_s         = rsp_y_r;
    rsp_not_valid_s = rsp_not_valid_r;
    timeout_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          owner_s   = pick_s;
          gnt_s     = onehot(pick_s);
          bit_cnt_s = 8'd0;
          state_s   = ST_LOAD;
        end else begin
          gnt_s = '0;
        end
      end
      ST_LOAD: begin
        if (src_valid[owner_r]) begin
          ms_in_valid_s = 1'b1;
          ms_maze_s     = src_maze[owner_r];
          bit_cnt_s     = bit_cnt_r + 8'd1;
          // The solver cannot take a partial maze, so the grant only ends on the last bit.
          if (bit_cnt_r == 8'(CELLS - 1)) begin
            gnt_s     = '0;
            tmo_cnt_s = '0;
            state_s   = ST_SOLVE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          ms_in_valid_s = 1'b0;
        end
      end
      ST_SOLVE: begin
        if (ms_out_valid) begin
          rsp_valid_s     = onehot(owner_r);
          rsp_x_s         = ms_out_x;
          rsp_y_s         = ms_out_y;
          rsp_not_valid_s = ms_maze_not_valid;
          state_s         = ST_DRAIN;
        end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
          rsp_valid_s     = onehot(owner_r);
          rsp_x_s         = 4'd0;
          rsp_y_s         = 4'd0;
          rsp_not_valid_s = 1'b1;
          timeout_s       = 1'b1;
          last_owner_s    = owner_r;
          state_s         = ST_IDLE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (ms_out_valid) begin
          rsp_valid_s     = onehot(owner_r);
          rsp_x_s         = ms_out_x;
          rsp_y_s         = ms_out_y;
          rsp_not_valid_s = ms_maze_not_valid;
        end else begin
          last_owner_s = owner_r;
          state_s      = ST_IDLE;
        end
      end
      default: begin
        gnt_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State register and registered outputs; the solver core shares this reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      owner_r         <= '0;
      last_owner_r    <= OW'(N_REQ - 1);
      bit_cnt_r       <= 8'd0;
      tmo_cnt_r       <= '0;
      gnt_r           <= '0;
      ms_in_valid_r   <= 1'b0;
      ms_maze_r       <= 1'b0;
      rsp_valid_r     <= '0;
      rsp_x_r         <= 4'd0;
      rsp_y_r         <= 4'd0;
      rsp_not_valid_r <= 1'b0;
      busy_r          <= 1'b0;
      timeout_r       <= 1'b0;
    end else begin
      state_r         <= state_s;
      owner_r         <= owner_s;
      last_owner_r    <= last_owner_s;
      bit_cnt_r       <= bit_cnt_s;
      tmo_cnt_r       <= tmo_cnt_s;
      gnt_r           <= gnt_s;
      ms_in_valid_r   <= ms_in_valid_s;
      ms_maze_r       <= ms_maze_s;
      rsp_valid_r     <= rsp_valid_s;
      rsp_x_r         <= rsp_x_s;
      rsp_y_r         <= rsp_y_s;
      rsp_not_valid_r <= rsp_not_valid_s;
      busy_r          <= busy_s;
      timeout_r       <= timeout_s;
    end
  end

  assign gnt           = gnt_r;
  assign ms_in_valid   = ms_in_valid_r;
  assign ms_maze       = ms_maze_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_x         = rsp_x_r;
  assign rsp_y         = rsp_y_r;
  assign rsp_not_valid = rsp_not_valid_r;
  assign busy          = busy_r;
  assign timeout       = timeout_r;

endmodule
